debounce_multi: RTL and testbench
=================================

// Module: debounce_multi
// PURPOSE
//   Parametrised N-channel switch/button debouncer with an input synchroniser and
//   separate rise and fall edge ticks. Each channel is an independent 4-state filter.
//   A channel's level changes only after its input has been stable for HOLD cycles.
//   Sits between raw board pins (KEY/SW) and control logic such as UART, LED and
//   counter blocks. It replaces per-pin single-channel debouncer instances.
// PARAMETERS
//   CH          4        number of independent channels
//   HOLD        2000000  stable cycles required before a level change (40 ms @ 50 MHz); >= 1
//   SYNC_STAGES 2        synchroniser flops per channel; >= 2
//   INIT_LEVEL  0        reset value of synchroniser flops and db_level (all channels)
//   CNT_W       $clog2(HOLD+1)  derived localparam; counter width
// PORTS
//   clk        in   1    system clock
//   reset      in   1    asynchronous, active-high reset
//   sw         in   CH   raw asynchronous inputs, bit i = channel i
//   db_level   out  CH   debounced level per channel (registered)
//   rise_tick  out  CH   1-cycle pulse when db_level[i] goes 0->1
//   fall_tick  out  CH   1-cycle pulse when db_level[i] goes 1->0
//   any_tick   out  1    registered OR of all rise_tick|fall_tick bits in the same cycle
// BEHAVIOUR
//   - Reset (async assert, sync release): sync flops=INIT_LEVEL; state=ONE if INIT_LEVEL
//     else ZERO; counter=0; db_level=INIT_LEVEL; rise/fall/any_tick=0.
//   - Sync: s[i] = last stage of a SYNC_STAGES flop chain on sw[i]. The FSM sees only s[i].
//   - Per-channel FSM, all transitions on posedge clk:
//     ZERO : s=1 -> WAIT1, cnt<=HOLD-1; else stay
//     WAIT1: s=0 -> ZERO (no tick); s=1 & cnt==0 -> ONE, rise_tick<=1;
//            s=1 & cnt!=0 -> cnt<=cnt-1
//     ONE  : s=0 -> WAIT0, cnt<=HOLD-1; else stay
//     WAIT0: s=1 -> ONE (no tick); s=0 & cnt==0 -> ZERO, fall_tick<=1;
//            s=0 & cnt!=0 -> cnt<=cnt-1
//   - db_level = 1 in ONE/WAIT0, 0 in ZERO/WAIT1. It is registered and updates on the same
//     edge as the tick. Ticks are high for exactly one cycle.
//   - Latency: sw held stable from edge k -> db_level/tick change at edge k+SYNC_STAGES+HOLD.
//   - Glitch rule: any reversal of s during WAIT1/WAIT0 aborts the change with no tick. The
//     next qualifying edge restarts the count from HOLD-1 (no accumulation).
//   - HOLD=1: the level changes 1 cycle after entering WAIT*, if s is still stable.
//   - Counter never wraps. It is only decremented when nonzero and only loaded on WAIT* entry.
//   - Channels are fully independent. Simultaneous ticks on several channels are all reported.
//     any_tick is 1 for that single cycle.
//   - rise_tick and fall_tick are never both 1 on the same channel in the same cycle.
//   - Reset mid-WAIT*: the pending change is discarded and no tick is emitted.
// STRUCTURE
//   - Package debounce_pkg: 2-bit state encodings ZERO=0, WAIT1=1, ONE=2, WAIT0=3.
//   - Sub-module debounce_chan (HOLD, SYNC_STAGES, INIT_LEVEL): synchroniser, FSM, counter
//     and tick registers for one channel.
//   - Top: generate loop of CH debounce_chan instances plus the any_tick register.
//   - FSM coding: separate state/counter register block and next-state block; all
//     next-state defaults assigned before the case.
// TESTING  (bench params: CH=4, HOLD=8, SYNC_STAGES=2, INIT_LEVEL=0)
//   - Reset: assert reset mid-run with sw=4'hF -> outputs 0 at once; after release, db_level
//     stays 0 for 9 edges, then at edge 10 = 4'hF, rise_tick=4'hF, any_tick=1 for 1 cycle.
//   - Clean press: sw[0] 0->1 at edge k -> db_level[0]=1 and rise_tick[0]=1 at edge k+10;
//     rise_tick[0]=0 at k+11.
//   - Bounce reject: sw[1] high for 7 cycles, low for 3, then high steady. No tick during the
//     7 cycles; rise_tick[1] at 10 edges after the final rise.
//   - Release bounce: in ONE, sw[2] low for 5 cycles then high -> db_level[2] stays 1,
//     fall_tick never pulses.
//   - Simultaneous: sw=4'b0101 rising at the same edge -> rise_tick=4'b0101 in one cycle,
//     any_tick=1 for one cycle; channels 1 and 3 unchanged.
//   - Random bounce (1-12 cycle pulses, 10k cycles) vs. reference model: db_level/ticks
//     match every cycle; never rise&fall on one channel.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types for the multi-channel debouncer: per-channel filter state encoding
// and the level each state presents on db_level.
package debounce_pkg;

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } state_t;

  // A channel keeps showing its old level while it waits for the change to qualify.
  function automatic logic level_of(input state_t st);
    return (st == ONE) || (st == WAIT0);
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debouncer channel: input synchroniser, 4-state stability filter with a
// down-counter, and registered level / rise / fall outputs.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int   HOLD        = 2000000,
  parameter int   SYNC_STAGES = 2,
  parameter logic INIT_LEVEL  = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic sw,
  output logic level,
  output logic rise,
  output logic fall,
  output logic tick_next
);

  localparam int               CNT_W      = $clog2(HOLD + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(HOLD - 1);
  localparam state_t           STATE_INIT = INIT_LEVEL ? ONE : ZERO;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_t                 state, state_d;
  logic [CNT_W-1:0]       cnt, cnt_d;
  logic                   level_d, rise_d, fall_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= {SYNC_STAGES{INIT_LEVEL}};
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], sw};
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= STATE_INIT;
      cnt   <= '0;
      level <= INIT_LEVEL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      level <= level_d;
      rise  <= rise_d;
      fall  <= fall_d;
    end
  end

  // NOTE: defaults before the case keep this block free of inferred latches.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    unique case (state)
      ZERO: begin
        if (s) begin
          state_d = WAIT1;
          cnt_d   = CNT_LOAD;
        end
      end
      WAIT1: begin
        if (!s)             state_d = ZERO;
        else if (cnt == '0) state_d = ONE;
        else                cnt_d   = cnt - CNT_W'(1);
      end
      ONE: begin
        if (!s) begin
          state_d = WAIT0;
          cnt_d   = CNT_LOAD;
        end
      end
      WAIT0: begin
        if (s)              state_d = ONE;
        else if (cnt == '0) state_d = ZERO;
        else                cnt_d   = cnt - CNT_W'(1);
      end
    endcase
  end

  // Ticks fire only on a completed wait, never on an aborted one.
  always_comb begin
    level_d = level_of(state_d);
    rise_d  = (state == WAIT1) && (state_d == ONE);
    fall_d  = (state == WAIT0) && (state_d == ZERO);
  end

  assign tick_next = rise_d | fall_d;

endmodule

// File: rtl/debounce_multi.sv
// N-channel switch debouncer: independent per-channel filters plus a combined
// any_tick flag aligned with the individual rise/fall ticks.
module debounce_multi #(
  parameter int   CH          = 4,
  parameter int   HOLD        = 2000000,
  parameter int   SYNC_STAGES = 2,
  parameter logic INIT_LEVEL  = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [CH-1:0] sw,
  output logic [CH-1:0] db_level,
  output logic [CH-1:0] rise_tick,
  output logic [CH-1:0] fall_tick,
  output logic          any_tick
);

  logic [CH-1:0] tick_next;

  for (genvar g = 0; g < CH; g++) begin : g_chan
    debounce_chan #(
      .HOLD        (HOLD),
      .SYNC_STAGES (SYNC_STAGES),
      .INIT_LEVEL  (INIT_LEVEL)
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .sw        (sw[g]),
      .level     (db_level[g]),
      .rise      (rise_tick[g]),
      .fall      (fall_tick[g]),
      .tick_next (tick_next[g])
    );
  end

  // Registered from the channels' next-tick terms so it lands in the same cycle as the ticks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) any_tick <= 1'b0;
    else       any_tick <= |tick_next;
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Self-checking bench for debounce_multi: directed scenarios plus random bouncing
// inputs compared every cycle against a run-length reference model.
module tb_debounce_multi;

  localparam int   CH   = 4;
  localparam int   HOLD = 8;
  localparam int   SYNC = 2;
  localparam logic INIT = 1'b0;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [CH-1:0] sw = '0;
  logic [CH-1:0] db_level, rise_tick, fall_tick;
  logic          any_tick;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: sw delayed SYNC edges, then a level flips once the delayed
  // input has disagreed with it on HOLD+1 consecutive edges.
  logic [CH-1:0] m_sync [SYNC];
  logic [CH-1:0] m_level, m_rise, m_fall;
  int            m_run  [CH];
  int            dur    [CH];

  always #5 clk = ~clk;

  debounce_multi #(
    .CH          (CH),
    .HOLD        (HOLD),
    .SYNC_STAGES (SYNC),
    .INIT_LEVEL  (INIT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sw        (sw),
    .db_level  (db_level),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick),
    .any_tick  (any_tick)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < SYNC; j++) m_sync[j] = {CH{INIT}};
    m_level = {CH{INIT}};
    m_rise  = '0;
    m_fall  = '0;
    for (int i = 0; i < CH; i++) m_run[i] = 0;
  endtask

  task automatic model_edge();
    logic s;
    m_rise = '0;
    m_fall = '0;
    for (int i = 0; i < CH; i++) begin
      s = m_sync[SYNC-1][i];
      if (s != m_level[i]) begin
        m_run[i]++;
        if (m_run[i] == HOLD + 1) begin
          m_level[i] = s;
          if (s) m_rise[i] = 1'b1;
          else   m_fall[i] = 1'b1;
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    for (int j = SYNC - 1; j > 0; j--) m_sync[j] = m_sync[j-1];
    m_sync[0] = sw;
  endtask

  // Drive on the falling edge, advance the model on the rising edge, compare 1 ns later.
  task automatic step(input logic [CH-1:0] v);
    @(negedge clk);
    sw = v;
    @(posedge clk);
    model_edge();
    #1;
    check("level", db_level, m_level);
    check("rise", rise_tick, m_rise);
    check("fall", fall_tick, m_fall);
    check("any", any_tick, |(m_rise | m_fall));
    check("rise_fall_excl", rise_tick & fall_tick, 0);
  endtask

  initial begin
    model_reset();
    #1 reset = 1'b1;
    #1;
    check("rst_level", db_level, 0);
    check("rst_rise", rise_tick, 0);
    check("rst_fall", fall_tick, 0);
    check("rst_any", any_tick, 0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    repeat (3) step(4'b0000);

    // Clean press on channel 0: level and tick at edge k+SYNC+HOLD.
    for (int i = 0; i <= 11; i++) begin
      step(4'b0001);
      if (i == 9)  check("press_early", db_level[0], 0);
      if (i == 10) begin
        check("press_level", db_level[0], 1);
        check("press_rise", rise_tick[0], 1);
      end
      if (i == 11) check("press_rise_off", rise_tick[0], 0);
    end

    // Bounce on channel 1: 7 high, 3 low, then steady high.
    for (int i = 0; i < 7; i++) begin
      step(4'b0011);
      check("bounce_no_rise", rise_tick[1], 0);
    end
    repeat (3) step(4'b0001);
    for (int i = 0; i <= 11; i++) begin
      step(4'b0011);
      if (i == 9)  check("bounce_early", db_level[1], 0);
      if (i == 10) check("bounce_rise", rise_tick[1], 1);
    end

    // Release bounce on channel 2 once it is high.
    repeat (12) step(4'b0111);
    check("rel_up", db_level[2], 1);
    for (int i = 0; i < 20; i++) begin
      step(i < 5 ? 4'b0011 : 4'b0111);
      check("rel_level", db_level[2], 1);
      check("rel_no_fall", fall_tick[2], 0);
    end

    repeat (15) step(4'b0000);
    check("all_low", db_level, 0);

    // Simultaneous rise on channels 0 and 2.
    for (int i = 0; i <= 11; i++) begin
      step(4'b0101);
      if (i == 10) begin
        check("sim_rise", rise_tick, 4'b0101);
        check("sim_any", any_tick, 1);
        check("sim_level", db_level, 4'b0101);
      end
      if (i == 11) begin
        check("sim_rise_off", rise_tick, 0);
        check("sim_any_off", any_tick, 0);
      end
    end

    // Reset while channels 1 and 3 are mid-wait: pending change is discarded.
    repeat (5) step(4'b1111);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_level", db_level, 0);
    check("mid_rst_rise", rise_tick, 0);
    check("mid_rst_fall", fall_tick, 0);
    check("mid_rst_any", any_tick, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    for (int i = 0; i <= 11; i++) begin
      step(4'b1111);
      if (i <= 9) check("post_rst_low", db_level, 0);
      if (i == 10) begin
        check("post_rst_level", db_level, 4'hF);
        check("post_rst_rise", rise_tick, 4'hF);
        check("post_rst_any", any_tick, 1);
      end
      if (i == 11) check("post_rst_rise_off", rise_tick, 0);
    end

    // Random bouncing: mostly 1-12 cycle pulses, sometimes long enough to qualify.
    for (int i = 0; i < CH; i++) dur[i] = $urandom_range(1, 12);
    for (int n = 0; n < 10000; n++) begin
      logic [CH-1:0] v;
      v = sw;
      for (int i = 0; i < CH; i++) begin
        dur[i]--;
        if (dur[i] <= 0) begin
          v[i]   = ~v[i];
          dur[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 30) : $urandom_range(1, 12);
        end
      end
      step(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
